// File: rtl/sp1_decmux_unit_pkg.sv
// Shared constants for the sp1 decode/mux slice: default data width and reset levels.
package sp1_decmux_unit_pkg;

  localparam int DW_DEFAULT = 8;

  // Reset levels; rst is active-high throughout sp1.
  localparam logic RST_HIGH = 1'b1;
  localparam logic RST_LOW  = 1'b0;

  // Decoder widths used by the top level.
  localparam int DEC_SMALL_N = 2;
  localparam int DEC_LARGE_N = 3;

endpackage

// File: rtl/sp1_dec_onehot.sv
// Combinational N-to-2^N one-hot decoder with enable; en=0 yields all-zero.
module sp1_dec_onehot #(
  parameter int N = 2
) (
  input  logic [N-1:0]      sel,
  input  logic              en,
  output logic [2**N-1:0]   onehot
);

  localparam logic [2**N-1:0] ONE = {{(2**N-1){1'b0}}, 1'b1};

  // A shift keeps X on sel visible as X on every output bit in 4-state simulation.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot = ONE << sel;
    end
  end

endmodule

// File: rtl/sp1_decmux_unit.sv
// Registered 2-to-4 decoder, 3-to-8 decoder and DW-bit 2:1 mux with 1-cycle latency.
// Optional decoder enable input is added when SP1_DECMUX_ENABLE_EN is defined.
module sp1_decmux_unit
  import sp1_decmux_unit_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    e,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  input  logic          s,
`ifdef SP1_DECMUX_ENABLE_EN
  input  logic          en,
`endif
  output logic [3:0]    dec2_4_d,
  output logic [7:0]    dec3_8_d,
  output logic [DW-1:0] mux2_y
);

  logic          dec_en;
  logic [3:0]    dec2_4_c;
  logic [7:0]    dec3_8_c;
  logic [DW-1:0] mux2_c;

`ifdef SP1_DECMUX_ENABLE_EN
  assign dec_en = en;
`else
  assign dec_en = 1'b1;
`endif

  sp1_dec_onehot #(.N(DEC_SMALL_N)) u_dec2_4 (
    .sel    (e[1:0]),
    .en     (dec_en),
    .onehot (dec2_4_c)
  );

  sp1_dec_onehot #(.N(DEC_LARGE_N)) u_dec3_8 (
    .sel    (e[2:0]),
    .en     (dec_en),
    .onehot (dec3_8_c)
  );

  // Ternary merges bitwise on an unknown select, so bits where a0 and a1 agree stay known.
  assign mux2_c = s ? a1 : a0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_HIGH) begin
      dec2_4_d <= 4'h0;
      dec3_8_d <= 8'h00;
      mux2_y   <= '0;
    end else begin
      dec2_4_d <= dec2_4_c;
      dec3_8_d <= dec3_8_c;
      mux2_y   <= mux2_c;
    end
  end

endmodule

// File: tb/tb_sp1_decmux_unit.sv
// Directed bench for sp1_decmux_unit; define SP1_DECMUX_ENABLE_EN to exercise the enable port.
module tb_sp1_decmux_unit;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [2:0]    e;
  logic [DW-1:0] a0;
  logic [DW-1:0] a1;
  logic          s;
`ifdef SP1_DECMUX_ENABLE_EN
  logic          en;
`endif
  logic [3:0]    dec2_4_d;
  logic [7:0]    dec3_8_d;
  logic [DW-1:0] mux2_y;

  int n_checks;
  int n_fail;

  sp1_decmux_unit #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .e        (e),
    .a0       (a0),
    .a1       (a1),
    .s        (s),
`ifdef SP1_DECMUX_ENABLE_EN
    .en       (en),
`endif
    .dec2_4_d (dec2_4_d),
    .dec3_8_d (dec3_8_d),
    .mux2_y   (mux2_y)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e2, input logic [7:0] e3,
                           input logic [7:0] ey);
    check({tag, ".dec2_4"}, {4'h0, dec2_4_d}, {4'h0, e2});
    check({tag, ".dec3_8"}, dec3_8_d, e3);
    check({tag, ".mux2"},   mux2_y,   ey);
  endtask

  initial begin
    logic [3:0] exp2;
    logic [7:0] exp3;
    logic [7:0] low_nib;
    n_checks = 0;
    n_fail   = 0;

    // 1. Reset with random inputs, no clock edge yet
    rst = 1'b1;
    e   = 3'($urandom_range(0, 7));
    a0  = 8'($urandom_range(0, 255));
    a1  = 8'($urandom_range(0, 255));
    s   = 1'($urandom_range(0, 1));
`ifdef SP1_DECMUX_ENABLE_EN
    en  = 1'b1;
`endif
    #2;
    check_all("reset_no_edge", 4'h0, 8'h00, 8'h00);
    step();
    check_all("reset_held", 4'h0, 8'h00, 8'h00);
    rst = 1'b0;
    e   = 3'd0;
    s   = 1'b0;
    a0  = 8'h00;
    check_all("post_release", 4'h0, 8'h00, 8'h00);

    // 2. Decoder sweep
    for (int i = 0; i < 8; i++) begin
      e = 3'(i);
      step();
      exp2 = 4'h1 << (i % 4);
      exp3 = 8'h01 << i;
      check($sformatf("sweep_dec2_4_e%0d", i), {4'h0, dec2_4_d}, {4'h0, exp2});
      check($sformatf("sweep_dec3_8_e%0d", i), dec3_8_d, exp3);
    end

    // 3. Mux
    a0 = 8'h5A; a1 = 8'hA5; s = 1'b0;
    step();
    check("mux_s0", mux2_y, 8'h5A);
    s = 1'b1;
    step();
    check("mux_s1", mux2_y, 8'hA5);
    a1 = 8'h3C;
    step();
    check("mux_a1_change", mux2_y, 8'h3C);
    step();
    check_all("hold_steady", 4'h8, 8'h80, 8'h3C);

    // 4. Mid-run reset between edges while dec3_8_d = 80
    #2;
    rst = 1'b1;
    #1;
    check_all("midrun_reset", 4'h0, 8'h00, 8'h00);
    step();
    check_all("midrun_reset_edge", 4'h0, 8'h00, 8'h00);
    rst = 1'b0;
    check_all("midrun_release", 4'h0, 8'h00, 8'h00);
    step();
    check_all("midrun_recover", 4'h8, 8'h80, 8'h3C);

    // 5. Unknown select: bits where a0 and a1 agree stay known
    a0 = 8'hFF; a1 = 8'h0F; s = 1'bx;
    step();
    low_nib = {4'h0, mux2_y[3:0]};
    check("mux_sel_x_low", low_nib, 8'h0F);
    s = 1'b0;

    // Decoder with e[2] set ignored by dec2_4
    e = 3'd6;
    step();
    check_all("e6", 4'h4, 8'h40, 8'hFF);

`ifdef SP1_DECMUX_ENABLE_EN
    // 6. Enable gating
    e = 3'd5; en = 1'b0; a0 = 8'h11; s = 1'b0;
    step();
    check_all("en0", 4'h0, 8'h00, 8'h11);
    en = 1'b1;
    step();
    check_all("en1", 4'h2, 8'h20, 8'h11);
`endif

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
